score_sequencer: RTL and testbench

- Sequences the 4-digit BCD score counter.
- Accepts one-cycle hit pulses from four point sources: alien rows 10/20/30 and the mystery ship.
- Queues hits per source and arbitrates between sources round-robin.
- Pays each hit out as a burst of single-count enable pulses on the counter's En input; also owns the counter's score-clear strobe.

---
 rtl/score_sequencer.sv | 206 ++++++++++++++++++++
 tb/tb_score_sequencer.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/score_sequencer.sv
// Score payout sequencer: queues per-source hits, picks sources round-robin and
// pays each hit out as a burst of single-count enables to the BCD score counter.
module score_sequencer #(
    parameter logic [7:0] PTS0   = 8'd10,
    parameter logic [7:0] PTS1   = 8'd20,
    parameter logic [7:0] PTS2   = 8'd30,
    parameter logic [7:0] PTS3   = 8'd50,
    parameter int         PEND_W = 4,
    parameter int         GAP    = 0
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [3:0] hit,
    input  logic       clr,
    input  logic       freeze,
    output logic       cnt_en,
    output logic       cnt_clr,
    output logic [3:0] grant,
    output logic       busy,
    output logic       drop,
    output logic [1:0] dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PAY   = 2'd1,
        CLEAR = 2'd2
    } state_t;

    localparam logic [7:0]        GAP_V    = 8'(GAP);
    localparam logic [PEND_W-1:0] PEND_MAX = '1;

    state_t            r_state;
    state_t            w_next;
    logic [PEND_W-1:0] r_pend [4];
    logic [7:0]        r_remaining;
    logic [7:0]        r_pace;
    logic [1:0]        r_rr_last;
    logic [3:0]        r_grant;
    logic              r_drop;

    logic              w_found;
    logic              w_any_pend;
    logic [1:0]        w_sel;
    logic              w_take;
    logic              w_cnt_en;
    logic [3:0]        w_dec;
    logic [3:0]        w_hit_ok;
    logic [3:0]        w_ovf;

    function automatic logic [7:0] pts_of(input logic [1:0] s);
        case (s)
            2'd0:    return PTS0;
            2'd1:    return PTS1;
            2'd2:    return PTS2;
            default: return PTS3;
        endcase
    endfunction

    // Round-robin scan starts just after the last granted source and wraps.
    always_comb begin
        w_found    = 1'b0;
        w_sel      = 2'd0;
        w_any_pend = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            if (!w_found && (r_pend[r_rr_last + 2'(k)] != '0)) begin
                w_found = 1'b1;
                w_sel   = r_rr_last + 2'(k);
            end
        end
        for (int i = 0; i < 4; i++) begin
            if (r_pend[i] != '0) begin
                w_any_pend = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_take   = 1'b0;
        w_cnt_en = 1'b0;
        case (r_state)
            IDLE: begin
                if (clr) begin
                    w_next = CLEAR;
                end else if (!freeze && w_found) begin
                    w_take = 1'b1;
                    w_next = PAY;
                end
            end
            PAY: begin
                if (clr) begin
                    w_next = CLEAR;
                end else if (!freeze) begin
                    if (r_remaining == 8'd0) begin
                        w_next = IDLE;
                    end else if (r_pace == 8'd0) begin
                        w_cnt_en = 1'b1;
                        if (r_remaining == 8'd1) begin
                            w_next = IDLE;
                        end
                    end
                end
            end
            CLEAR:   w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // A hit seen together with the clear request is dropped; hits during CLEAR are kept.
    always_comb begin
        if (r_state == CLEAR) begin
            w_hit_ok = hit;
        end else if (clr) begin
            w_hit_ok = 4'b0000;
        end else begin
            w_hit_ok = hit;
        end
        w_dec = w_take ? (4'b0001 << w_sel) : 4'b0000;
        for (int i = 0; i < 4; i++) begin
            w_ovf[i] = w_hit_ok[i] & ~w_dec[i] & (r_pend[i] == PEND_MAX) & (r_state != CLEAR);
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < 4; i++) begin
                r_pend[i] <= '0;
            end
            r_drop <= 1'b0;
        end else begin
            r_drop <= |w_ovf;
            for (int i = 0; i < 4; i++) begin
                if (r_state == CLEAR) begin
                    r_pend[i] <= PEND_W'(hit[i]);
                end else if (w_hit_ok[i] && !w_dec[i]) begin
                    if (r_pend[i] != PEND_MAX) begin
                        r_pend[i] <= r_pend[i] + 1'b1;
                    end
                end else if (!w_hit_ok[i] && w_dec[i]) begin
                    r_pend[i] <= r_pend[i] - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_remaining <= 8'd0;
            r_pace      <= 8'd0;
            r_rr_last   <= 2'd3;
            r_grant     <= 4'b0000;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_take) begin
                        r_remaining <= pts_of(w_sel);
                        r_pace      <= 8'd0;
                        r_rr_last   <= w_sel;
                        r_grant     <= 4'b0001 << w_sel;
                    end
                end
                PAY: begin
                    if (clr) begin
                        r_remaining <= 8'd0;
                        r_pace      <= 8'd0;
                        r_grant     <= 4'b0000;
                    end else if (w_cnt_en) begin
                        r_remaining <= r_remaining - 8'd1;
                        r_pace      <= GAP_V;
                        if (w_next == IDLE) begin
                            r_grant <= 4'b0000;
                        end
                    end else if (!freeze) begin
                        if (r_remaining == 8'd0) begin
                            r_grant <= 4'b0000;
                        end else if (r_pace != 8'd0) begin
                            r_pace <= r_pace - 8'd1;
                        end
                    end
                end
                default: begin
                    r_remaining <= 8'd0;
                    r_pace      <= 8'd0;
                    r_grant     <= 4'b0000;
                end
            endcase
        end
    end

    assign cnt_en    = w_cnt_en;
    assign cnt_clr   = (r_state == CLEAR);
    assign grant     = r_grant;
    assign busy      = (r_state != IDLE) | w_any_pend;
    assign drop      = r_drop;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_score_sequencer.sv
// Directed bench for score_sequencer: a driver issues hits and pushes the expected
// bursts {source, pulse count}; a monitor pops and compares each finished burst.
module tb_score_sequencer;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [3:0] hit = 4'b0000;
  logic       clr = 1'b0;
  logic       freeze = 1'b0;
  logic       cnt_en, cnt_clr, busy, drop;
  logic [3:0] grant;
  logic [1:0] dbg_state;

  logic [3:0] g_hit = 4'b0000;
  logic       g_freeze = 1'b0;
  logic       g_clr = 1'b0;
  logic       g_cnt_en, g_cnt_clr, g_busy, g_drop;
  logic [3:0] g_grant;
  logic [1:0] g_dbg_state;

  score_sequencer dut (
    .CLK(CLK), .RST(RST), .hit(hit), .clr(clr), .freeze(freeze),
    .cnt_en(cnt_en), .cnt_clr(cnt_clr), .grant(grant), .busy(busy),
    .drop(drop), .dbg_state(dbg_state)
  );

  score_sequencer #(.GAP(2)) dut_g (
    .CLK(CLK), .RST(RST), .hit(g_hit), .clr(g_clr), .freeze(g_freeze),
    .cnt_en(g_cnt_en), .cnt_clr(g_cnt_clr), .grant(g_grant), .busy(g_busy),
    .drop(g_drop), .dbg_state(g_dbg_state)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_err = 0;
  int cyc = 0;
  logic [9:0] exp_q[$];
  int gap_q[$];
  int g_pulse_q[$];
  int en_total = 0;
  int drop_total = 0;
  int clr_total = 0;
  logic [3:0] mon_cur = 4'b0000;
  int mon_cnt = 0;
  int idle_run = 0;
  bit have_prev = 1'b0;
  bit stable_bad = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [1:0] enc(input logic [3:0] g);
    if (g[1]) return 2'd1;
    if (g[2]) return 2'd2;
    if (g[3]) return 2'd3;
    return 2'd0;
  endfunction

  always @(posedge CLK) cyc++;

  always @(negedge CLK) begin
    if (RST && g_cnt_en) g_pulse_q.push_back(cyc);
  end

  // Monitor: a burst runs from grant going non-zero to grant returning to zero.
  always @(negedge CLK) begin
    logic [9:0] e;
    if (!RST) begin
      mon_cur = 4'b0000;
      have_prev = 1'b0;
      stable_bad = 1'b0;
    end else begin
      if (cnt_en) en_total++;
      if (drop) drop_total++;
      if (cnt_clr) clr_total++;
      if (grant != 4'b0000) begin
        if (mon_cur == 4'b0000) begin
          mon_cur = grant;
          mon_cnt = 0;
          stable_bad = 1'b0;
          if (have_prev) gap_q.push_back(idle_run);
        end else if (grant != mon_cur) begin
          stable_bad = 1'b1;
        end
        if (cnt_en) mon_cnt++;
      end else begin
        chk("en_without_grant", cnt_en, 0);
        if (mon_cur != 4'b0000) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_burst", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("burst_src", enc(mon_cur), e[9:8]);
            chk("burst_len", mon_cnt, e[7:0]);
            chk("grant_stable", stable_bad, 0);
          end
          mon_cur = 4'b0000;
          have_prev = 1'b1;
          idle_run = 1;
        end else begin
          idle_run++;
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic do_reset();
    hit = 4'b0000; clr = 1'b0; freeze = 1'b0;
    g_hit = 4'b0000; g_freeze = 1'b0;
    RST = 1'b0;
    step(2);
    RST = 1'b1;
    step(1);
  endtask

  task automatic wait_idle(input string name, input int budget);
    int k = 0;
    while ((exp_q.size() != 0 || busy || g_busy) && k < budget) begin
      @(negedge CLK);
      k++;
    end
    chk(name, (k < budget) ? 1 : 0, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, e0, d0, c0;
    int t4_exp[10] = '{2, 5, 8, 11, 19, 22, 25, 28, 31, 34};

    @(negedge CLK);
    chk("rst_cnt_en", cnt_en, 0);
    chk("rst_cnt_clr", cnt_clr, 0);
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    chk("rst_drop", drop, 0);
    chk("rst_state", dbg_state, 0);

    // Single hit on source 0: ten pulses in cycles 2..11, busy from cycle 1 to 11.
    do_reset();
    exp_q.push_back({2'd0, 8'd10});
    for (int c = 0; c <= 12; c++) begin
      hit = (c == 0) ? 4'b0001 : 4'b0000;
      @(negedge CLK);
      chk("t1_en", cnt_en, (c >= 2 && c <= 11) ? 1 : 0);
      chk("t1_grant", grant, (c >= 2 && c <= 11) ? 1 : 0);
      chk("t1_busy", busy, (c >= 1 && c <= 11) ? 1 : 0);
      step(1);
    end
    hit = 4'b0000;
    wait_idle("t1_done", 50);

    // All four sources at once: order 0,1,2,3 with one idle cycle between bursts.
    do_reset();
    gap_q.delete();
    e0 = en_total;
    exp_q.push_back({2'd0, 8'd10});
    exp_q.push_back({2'd1, 8'd20});
    exp_q.push_back({2'd2, 8'd30});
    exp_q.push_back({2'd3, 8'd50});
    hit = 4'b1111;
    step(1);
    hit = 4'b0000;
    wait_idle("t2_done", 300);
    chk("t2_en_total", en_total - e0, 110);
    chk("t2_gap_count", gap_q.size(), 3);
    foreach (gap_q[i]) chk("t2_gap_len", gap_q[i], 1);

    // Round robin: after source 2, scan resumes at 3 then wraps to 0 and 1.
    do_reset();
    exp_q.push_back({2'd2, 8'd30});
    exp_q.push_back({2'd3, 8'd50});
    exp_q.push_back({2'd0, 8'd10});
    exp_q.push_back({2'd1, 8'd20});
    for (int c = 0; c <= 9; c++) begin
      hit = (c == 0) ? 4'b0100 : (c == 5) ? 4'b0010 : (c == 8) ? 4'b1001 : 4'b0000;
      step(1);
    end
    hit = 4'b0000;
    wait_idle("t3_done", 300);

    // GAP=2 instance, freeze for cycles 12..16 right after the 4th pulse.
    do_reset();
    g_pulse_q.delete();
    t0 = cyc;
    for (int c = 0; c <= 40; c++) begin
      g_hit = (c == 0) ? 4'b0001 : 4'b0000;
      g_freeze = (c >= 12 && c <= 16) ? 1'b1 : 1'b0;
      if (c == 14) begin
        @(negedge CLK);
        chk("t4_grant_frozen", g_grant, 1);
        chk("t4_en_frozen", g_cnt_en, 0);
      end
      step(1);
    end
    g_freeze = 1'b0;
    chk("t4_pulse_count", g_pulse_q.size(), 10);
    for (int i = 0; i < 10; i++) begin
      if (i < g_pulse_q.size()) chk("t4_pulse_cycle", g_pulse_q[i] - t0, t4_exp[i]);
    end
    @(negedge CLK);
    chk("t4_busy_end", g_busy, 0);

    // Saturation: 16 hits on source 3 while frozen; the 16th is dropped.
    do_reset();
    freeze = 1'b1;
    d0 = drop_total;
    e0 = en_total;
    for (int c = 0; c <= 17; c++) begin
      hit = (c <= 15) ? 4'b1000 : 4'b0000;
      @(negedge CLK);
      chk("t5_drop", drop, (c == 16) ? 1 : 0);
      step(1);
    end
    hit = 4'b0000;
    chk("t5_drop_total", drop_total - d0, 1);
    @(negedge CLK);
    chk("t5_busy_frozen", busy, 1);
    chk("t5_grant_frozen", grant, 0);
    for (int i = 0; i < 15; i++) exp_q.push_back({2'd3, 8'd50});
    freeze = 1'b0;
    wait_idle("t5_done", 1200);
    chk("t5_en_total", en_total - e0, 750);

    // Clear on the 5th pulse slot of a source-2 burst with source 1 pending.
    do_reset();
    e0 = en_total;
    c0 = clr_total;
    exp_q.push_back({2'd2, 8'd4});
    for (int c = 0; c <= 9; c++) begin
      hit = (c == 0) ? 4'b0100 : (c == 3) ? 4'b0010 : (c == 6) ? 4'b0001 : 4'b0000;
      clr = (c == 6) ? 1'b1 : 1'b0;
      @(negedge CLK);
      if (c == 5) chk("t6_en_4th", cnt_en, 1);
      if (c == 6) chk("t6_en_on_clr", cnt_en, 0);
      if (c == 7) begin
        chk("t6_cnt_clr", cnt_clr, 1);
        chk("t6_state_clear", dbg_state, 2);
      end
      if (c == 8) begin
        chk("t6_cnt_clr_end", cnt_clr, 0);
        chk("t6_busy", busy, 0);
        chk("t6_grant", grant, 0);
      end
      step(1);
    end
    hit = 4'b0000;
    clr = 1'b0;
    step(5);
    chk("t6_en_total", en_total - e0, 4);
    chk("t6_clr_total", clr_total - c0, 1);
    chk("t6_queue_empty", exp_q.size(), 0);

    // Asynchronous reset in the middle of a burst stops it at once.
    do_reset();
    e0 = en_total;
    hit = 4'b0001;
    step(1);
    hit = 4'b0000;
    step(3);
    #2;
    RST = 1'b0;
    #1;
    chk("t7_en_in_reset", cnt_en, 0);
    chk("t7_grant_in_reset", grant, 0);
    chk("t7_busy_in_reset", busy, 0);
    step(1);
    RST = 1'b1;
    step(5);
    chk("t7_busy_after", busy, 0);
    chk("t7_en_total", en_total - e0, 2);
    chk("final_queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
